// File: rtl/uart_pkg.sv
// Shared UART scheduler types: data width, launch FSM encoding and a ceil-log2 helper.
// No logic, no latency; pure declarations.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } fsm_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester, sender and status signals of the UART TX scheduler.
// master = environment side (requesters + sender), slave = scheduler.
interface uart_tx_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 8
);
    import uart_pkg::*;

    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [NREQ-1:0]             in_valid;
    logic [UART_DATA_W*NREQ-1:0] in_data;
    logic [NREQ-1:0]             in_ready;
    logic [UART_DATA_W-1:0]      tx_data;
    logic                        tx_send;
    logic                        tx_sending;
    logic [CNT_W-1:0]            fifo_count;
    logic                        busy;
    logic                        drop_err;

    modport master (
        output in_valid, in_data, tx_sending,
        input  in_ready, tx_data, tx_send, fifo_count, busy, drop_err
    );

    modport slave (
        input  in_valid, in_data, tx_sending,
        output in_ready, tx_data, tx_send, fifo_count, busy, drop_err
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; registered storage/pointers/count, head read combinationally.
// Latency: pushed entry visible at head next cycle; push ignored when full, pop ignored when empty.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_vld && !empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a FIFO drained by a launch FSM driving one uart_sender.
// Latency: accept at t -> tx_send at t+2; backpressure: in_ready low while FIFO full or in reset.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_scheduler_if.slave bus
);

    localparam int RR_W  = clog2(NREQ);
    localparam int AW    = clog2(DEPTH);
    localparam int TMO_W = clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(BUSY_TIMEOUT);

    localparam logic [1:0] IDLE      = ST_IDLE;
    localparam logic [1:0] LAUNCH    = ST_LAUNCH;
    localparam logic [1:0] WAIT_BUSY = ST_WAIT_BUSY;
    localparam logic [1:0] WAIT_DONE = ST_WAIT_DONE;

    logic [RR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]             state_q, state_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   tx_send_q, tx_send_d;

    logic [NREQ-1:0]        gnt;
    logic [RR_W-1:0]        gnt_idx;
    logic                   gnt_vld;
    int                     scan_idx;

    logic                   fifo_pop_vld;
    logic [UART_DATA_W-1:0] fifo_push_dat;
    logic [UART_DATA_W-1:0] fifo_head_dat;
    logic                   fifo_full, fifo_empty;
    logic [AW:0]            fifo_cnt;
    logic                   drop_err_c;

    // Grant uses the registered count, so a same-cycle pop cannot re-open a full FIFO
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_vld  = 1'b0;
        scan_idx = 0;
        if (rst_n && !fifo_full) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = int'(rr_ptr_q) + k;
                if (scan_idx >= NREQ) begin
                    scan_idx = scan_idx - NREQ;
                end
                if (!gnt_vld && bus.in_valid[scan_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = RR_W'(scan_idx);
                end
            end
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == RR_W'(NREQ - 1)) ? '0 : gnt_idx + RR_W'(1);
        end
    end

    assign fifo_push_dat = bus.in_data[int'(gnt_idx)*UART_DATA_W +: UART_DATA_W];

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (gnt_vld),
        .push_dat (fifo_push_dat),
        .pop_vld  (fifo_pop_vld),
        .pop_dat  (fifo_head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        tx_data_d    = tx_data_q;
        fifo_pop_vld = 1'b0;
        drop_err_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop_vld = 1'b1;
                    tx_data_d    = fifo_head_dat;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_sending) begin
                    state_d = WAIT_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    // sender never acknowledged: abandon this byte
                    if (tmo_d == TMO_LIMIT) begin
                        drop_err_c = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_sending) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        tx_send_d = (state_d == LAUNCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            state_q   <= IDLE;
            tmo_q     <= '0;
            tx_data_q <= '0;
            tx_send_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
        end
    end

    assign bus.in_ready   = gnt;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_send    = tx_send_q;
    assign bus.fifo_count = fifo_cnt;
    assign bus.busy       = (state_q != IDLE) || !fifo_empty;
    assign bus.drop_err   = drop_err_c;

endmodule
